// File: rtl/riscv_core_mem_arbiter.sv
// Shares the single external memory port between icache refills, dcache refills and dcache stores.
// Round-robin between I and D sides; the granted command is latched and guarded by a watchdog.
module riscv_core_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned WDATA_WIDTH    = 32,
    parameter int unsigned STRB_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   i_clk,
    input  logic                   i_rst,

    input  logic                   i_ic_read_req,
    input  logic [ADDR_WIDTH-1:0]  i_ic_read_addr,
    output logic                   o_ic_read_done,

    input  logic                   i_dc_read_req,
    input  logic [ADDR_WIDTH-1:0]  i_dc_read_addr,
    output logic                   o_dc_read_done,

    input  logic                   i_dc_write_valid,
    input  logic [ADDR_WIDTH-1:0]  i_dc_write_addr,
    input  logic [WDATA_WIDTH-1:0] i_dc_write_data,
    input  logic [STRB_WIDTH-1:0]  i_dc_write_strobe,
    output logic                   o_dc_write_done,

    output logic [LINE_WIDTH-1:0]  o_read_data,

    output logic                   o_bus_valid,
    output logic                   o_bus_we,
    output logic [ADDR_WIDTH-1:0]  o_bus_addr,
    output logic [WDATA_WIDTH-1:0] o_bus_wdata,
    output logic [STRB_WIDTH-1:0]  o_bus_strobe,
    input  logic                   i_bus_done,
    input  logic [LINE_WIDTH-1:0]  i_bus_rdata,
    output logic                   o_bus_error,

    output logic                   o_busy
);

    localparam int unsigned CntWidth = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StIcRead, StDcRead, StDcWrite} state_e;

    state_e                 state_q;
    logic                   last_grant_q;  // 0: I side was last tie winner, 1: D side
    logic [CntWidth-1:0]    cnt_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [WDATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0]  strobe_q;
    logic                   valid_q;
    logic                   we_q;

    logic ic_pend;
    logic dc_pend;
    logic tie;
    logic grant_dc;
    logic active;
    logic timeout;
    logic finish;

    always_comb begin
        ic_pend  = i_ic_read_req;
        dc_pend  = i_dc_read_req | i_dc_write_valid;
        tie      = ic_pend & dc_pend;
        grant_dc = dc_pend & (~ic_pend | ~last_grant_q);
        active   = (state_q != StIdle);
        timeout  = active && (cnt_q == CntWidth'(TIMEOUT_CYCLES - 1));
        // Reset in the same cycle suppresses completion so the owner never sees a stray done.
        finish   = active & (i_bus_done | timeout) & ~i_rst;
    end

    assign o_ic_read_done  = finish & (state_q == StIcRead);
    assign o_dc_read_done  = finish & (state_q == StDcRead);
    assign o_dc_write_done = finish & (state_q == StDcWrite);
    assign o_bus_error     = finish & ~i_bus_done;
    assign o_busy          = active;
    assign o_read_data     = i_bus_rdata;
    assign o_bus_valid     = valid_q;
    assign o_bus_we        = we_q;
    assign o_bus_addr      = addr_q;
    assign o_bus_wdata     = wdata_q;
    assign o_bus_strobe    = strobe_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            strobe_q     <= '0;
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ic_pend || dc_pend) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        if (tie) begin
                            last_grant_q <= grant_dc;
                        end
                        if (grant_dc && i_dc_write_valid) begin
                            state_q  <= StDcWrite;
                            addr_q   <= i_dc_write_addr;
                            wdata_q  <= i_dc_write_data;
                            strobe_q <= i_dc_write_strobe;
                            we_q     <= 1'b1;
                        end else if (grant_dc) begin
                            state_q  <= StDcRead;
                            addr_q   <= i_dc_read_addr;
                            wdata_q  <= '0;
                            strobe_q <= '0;
                            we_q     <= 1'b0;
                        end else begin
                            state_q  <= StIcRead;
                            addr_q   <= i_ic_read_addr;
                            wdata_q  <= '0;
                            strobe_q <= '0;
                            we_q     <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (i_bus_done || timeout) begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CntWidth'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Directed bench for riscv_core_mem_arbiter with a 4-cycle watchdog.
module tb_riscv_core_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_done;
    logic         dc_req;
    logic [31:0]  dc_addr;
    logic         dc_rdone;
    logic         wr_valid;
    logic [31:0]  wr_addr;
    logic [31:0]  wr_data;
    logic [7:0]   wr_strb;
    logic         wr_done;
    logic [255:0] read_data;
    logic         bus_valid;
    logic         bus_we;
    logic [31:0]  bus_addr;
    logic [31:0]  bus_wdata;
    logic [7:0]   bus_strb;
    logic         bus_done;
    logic [255:0] bus_rdata;
    logic         bus_error;
    logic         busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    riscv_core_mem_arbiter #(
        .ADDR_WIDTH    (32),
        .LINE_WIDTH    (256),
        .WDATA_WIDTH   (32),
        .STRB_WIDTH    (8),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_ic_read_req    (ic_req),
        .i_ic_read_addr   (ic_addr),
        .o_ic_read_done   (ic_done),
        .i_dc_read_req    (dc_req),
        .i_dc_read_addr   (dc_addr),
        .o_dc_read_done   (dc_rdone),
        .i_dc_write_valid (wr_valid),
        .i_dc_write_addr  (wr_addr),
        .i_dc_write_data  (wr_data),
        .i_dc_write_strobe(wr_strb),
        .o_dc_write_done  (wr_done),
        .o_read_data      (read_data),
        .o_bus_valid      (bus_valid),
        .o_bus_we         (bus_we),
        .o_bus_addr       (bus_addr),
        .o_bus_wdata      (bus_wdata),
        .o_bus_strobe     (bus_strb),
        .i_bus_done       (bus_done),
        .i_bus_rdata      (bus_rdata),
        .o_bus_error      (bus_error),
        .o_busy           (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ic_req = 0; dc_req = 0; wr_valid = 0; bus_done = 0;
        ic_addr = 0; dc_addr = 0; wr_addr = 0; wr_data = 0; wr_strb = 0; bus_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        total++; if (bus_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus_valid); else passed++;
        total++; if (bus_we !== 1'b0) $display("FAIL reset_we: got %b want 0", bus_we); else passed++;
        total++; if ({bus_addr, bus_wdata, bus_strb} !== 72'h0)
            $display("FAIL reset_cmd: got %h/%h/%h want 0", bus_addr, bus_wdata, bus_strb); else passed++;
        total++; if ({ic_done, dc_rdone, wr_done, bus_error, busy} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {ic_done, dc_rdone, wr_done, bus_error, busy});
        else passed++;
    endtask

    task automatic test_ic_refill();
        logic [255:0] pat;
        pat = {8{32'hA5A5_0000 + 32'h1234}};
        ic_req = 1; ic_addr = 32'h0000_1040;
        tick();
        total++; if (bus_valid !== 1'b1) $display("FAIL ic_grant_valid: got %b want 1", bus_valid); else passed++;
        total++; if (bus_addr !== 32'h1040) $display("FAIL ic_addr: got %h want 00001040", bus_addr); else passed++;
        total++; if (bus_we !== 1'b0) $display("FAIL ic_we: got %b want 0", bus_we); else passed++;
        tick(); tick(); tick();
        bus_done = 1; bus_rdata = pat; ic_req = 0;
        #1;
        total++; if (ic_done !== 1'b1) $display("FAIL ic_done: got %b want 1", ic_done); else passed++;
        total++; if (read_data !== pat) $display("FAIL ic_rdata: got %h want %h", read_data, pat); else passed++;
        total++; if ({dc_rdone, wr_done, bus_error} !== 3'b0)
            $display("FAIL ic_other_flags: got %b want 000", {dc_rdone, wr_done, bus_error}); else passed++;
        tick();
        bus_done = 0;
        #1;
        total++; if ({bus_valid, busy, ic_done} !== 3'b0)
            $display("FAIL ic_back_idle: got %b want 000", {bus_valid, busy, ic_done}); else passed++;
    endtask

    task automatic test_round_robin();
        ic_addr = 32'h0000_0100; dc_addr = 32'h0000_0200;
        ic_req = 1; dc_req = 1;
        tick();
        total++; if (bus_addr !== 32'h200) $display("FAIL tie1_first_d: got %h want 00000200", bus_addr); else passed++;
        bus_done = 1; dc_req = 0;
        #1;
        total++; if ({dc_rdone, ic_done} !== 2'b10) $display("FAIL tie1_d_done: got %b want 10", {dc_rdone, ic_done});
        else passed++;
        tick();
        bus_done = 0;
        #1;
        total++; if (bus_valid !== 1'b0) $display("FAIL turnaround_idle: got %b want 0", bus_valid); else passed++;
        tick();
        total++; if (bus_addr !== 32'h100) $display("FAIL tie1_second_i: got %h want 00000100", bus_addr); else passed++;
        bus_done = 1; ic_req = 0;
        #1;
        total++; if (ic_done !== 1'b1) $display("FAIL tie1_i_done: got %b want 1", ic_done); else passed++;
        tick();
        bus_done = 0;
        ic_req = 1; dc_req = 1;
        tick();
        total++; if (bus_addr !== 32'h100) $display("FAIL tie2_first_i: got %h want 00000100", bus_addr); else passed++;
        bus_done = 1; ic_req = 0;
        tick();
        bus_done = 0;
        tick();
        total++; if (bus_addr !== 32'h200) $display("FAIL tie2_second_d: got %h want 00000200", bus_addr); else passed++;
        bus_done = 1; dc_req = 0;
        tick();
        bus_done = 0;
        #1;
    endtask

    task automatic test_d_priority();
        wr_valid = 1; wr_addr = 32'h2004; wr_data = 32'hDEAD_BEEF; wr_strb = 8'h0F;
        dc_req = 1; dc_addr = 32'h3000;
        tick();
        total++; if (bus_we !== 1'b1) $display("FAIL dw_we: got %b want 1", bus_we); else passed++;
        total++; if ({bus_addr, bus_wdata, bus_strb} !== {32'h2004, 32'hDEAD_BEEF, 8'h0F})
            $display("FAIL dw_cmd: got %h/%h/%h want 00002004/deadbeef/0f", bus_addr, bus_wdata, bus_strb);
        else passed++;
        wr_addr = 32'hFFFF_FFF0; wr_data = 32'h0; wr_strb = 8'hFF; ic_req = 1; ic_addr = 32'h9999;
        tick();
        total++; if ({bus_we, bus_addr, bus_wdata, bus_strb} !== {1'b1, 32'h2004, 32'hDEAD_BEEF, 8'h0F})
            $display("FAIL dw_latched: got %b/%h/%h/%h want 1/00002004/deadbeef/0f",
                     bus_we, bus_addr, bus_wdata, bus_strb);
        else passed++;
        ic_req = 0;
        wr_valid = 0; bus_done = 1;
        #1;
        total++; if ({wr_done, dc_rdone} !== 2'b10) $display("FAIL dw_done: got %b want 10", {wr_done, dc_rdone});
        else passed++;
        tick();
        bus_done = 0;
        tick();
        total++; if ({bus_we, bus_addr, bus_strb, bus_wdata} !== {1'b0, 32'h3000, 8'h00, 32'h0})
            $display("FAIL dr_after_dw: got %b/%h/%h/%h want 0/00003000/00/0", bus_we, bus_addr, bus_strb, bus_wdata);
        else passed++;
        bus_done = 1; dc_req = 0;
        tick();
        bus_done = 0;
        #1;
    endtask

    task automatic test_timeout();
        dc_req = 1; dc_addr = 32'h4000;
        tick();
        for (int i = 0; i < 3; i++) begin
            total++; if ({bus_valid, dc_rdone, bus_error} !== 3'b100)
                $display("FAIL to_wait%0d: got %b want 100", i, {bus_valid, dc_rdone, bus_error});
            else passed++;
            tick();
        end
        dc_req = 0;
        #1;
        total++; if ({bus_valid, dc_rdone, bus_error} !== 3'b111)
            $display("FAIL to_fire: got %b want 111", {bus_valid, dc_rdone, bus_error}); else passed++;
        tick();
        total++; if ({bus_valid, dc_rdone, bus_error} !== 3'b000)
            $display("FAIL to_after: got %b want 000", {bus_valid, dc_rdone, bus_error}); else passed++;
        dc_req = 1;
        tick(); tick(); tick(); tick();
        bus_done = 1; dc_req = 0;
        #1;
        total++; if ({dc_rdone, bus_error} !== 2'b10)
            $display("FAIL to_done_wins: got %b want 10", {dc_rdone, bus_error}); else passed++;
        tick();
        bus_done = 0;
        #1;
        total++; if (bus_valid !== 1'b0) $display("FAIL to_done_idle: got %b want 0", bus_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        ic_addr = 32'h5000; dc_addr = 32'h6000;
        ic_req = 1; dc_req = 1;
        tick();
        bus_done = 1; dc_req = 0;
        tick();
        bus_done = 0;
        tick();
        total++; if ({bus_valid, bus_addr} !== {1'b1, 32'h5000})
            $display("FAIL rm_ic_active: got %b/%h want 1/00005000", bus_valid, bus_addr); else passed++;
        rst = 1;
        tick();
        rst = 0;
        #1;
        total++; if ({bus_valid, busy, ic_done, dc_rdone, wr_done} !== 5'b0)
            $display("FAIL rm_after: got %b want 00000", {bus_valid, busy, ic_done, dc_rdone, wr_done}); else passed++;
        total++; if (bus_addr !== 32'h0) $display("FAIL rm_cmd_clear: got %h want 0", bus_addr); else passed++;
        dc_req = 1;
        tick();
        total++; if (bus_addr !== 32'h6000) $display("FAIL rm_tie_d: got %h want 00006000", bus_addr); else passed++;
        bus_done = 1; dc_req = 0; ic_req = 0;
        #1;
        total++; if (dc_rdone !== 1'b1) $display("FAIL rm_d_done: got %b want 1", dc_rdone); else passed++;
        tick();
        bus_done = 0;
        #1;
    endtask

    task automatic test_stray_done();
        bus_done = 1;
        #1;
        total++; if ({ic_done, dc_rdone, wr_done, bus_error, bus_valid} !== 5'b0)
            $display("FAIL stray_flags: got %b want 00000", {ic_done, dc_rdone, wr_done, bus_error, bus_valid});
        else passed++;
        tick();
        bus_done = 0;
        #1;
        total++; if ({busy, bus_valid} !== 2'b0) $display("FAIL stray_state: got %b want 00", {busy, bus_valid});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_ic_refill();
        test_round_robin();
        test_d_priority();
        test_timeout();
        test_reset_mid();
        test_stray_done();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
